// File: rtl/encdec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : encdec_pkg
// Purpose  : Shared definitions for the encoder/decoder stream family.
//            Holds the transform-mode encodings, the two-state
//            handshake FSM encoding and a small mode helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package encdec_pkg;

  // Transform modes selected through cfg_mode.
  localparam logic [1:0] MODE_PASS    = 2'd0;
  localparam logic [1:0] MODE_INV     = 2'd1;
  localparam logic [1:0] MODE_GRP_REV = 2'd2;
  localparam logic [1:0] MODE_KEY_XOR = 2'd3;

  // Output-register occupancy FSM. BUSY means a beat is being presented.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Only the keystream mode consumes and advances the key.
  function automatic logic uses_key(input logic [1:0] mode);
    return (mode == MODE_KEY_XOR);
  endfunction

endpackage : encdec_pkg
`default_nettype wire

// File: rtl/encdec_transform.sv
`default_nettype none
// ============================================================================
// Module   : encdec_transform
// Purpose  : Purely combinational, self-inverse word transform.
//              MODE_PASS    : out = in
//              MODE_INV     : out = ~in
//              MODE_GRP_REV : bit order reversed inside every GROUP_W
//                             group, then inverted
//              MODE_KEY_XOR : out = in ^ key
//            Reusable by channelised variants that keep their own key.
// Ports    : mode     [1:0]        transform select
//            key      [DATA_W-1:0] keystream value (MODE_KEY_XOR only)
//            in_word  [DATA_W-1:0] word to transform
//            out_word [DATA_W-1:0] transformed word
// Revision : 1.0 - initial release
// ============================================================================
module encdec_transform
  import encdec_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GROUP_W = 4
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] key,
  input  logic [DATA_W-1:0] in_word,
  output logic [DATA_W-1:0] out_word
);

  localparam int N_GROUPS = DATA_W / GROUP_W;

  // A partial trailing group would make group-reverse ill-defined.
  if ((DATA_W % GROUP_W) != 0 || GROUP_W < 1) begin : g_bad_group
    $error("encdec_transform: DATA_W (%0d) must be a multiple of GROUP_W (%0d)",
           DATA_W, GROUP_W);
  end

  logic [DATA_W-1:0] w_grp_rev;

  // Mirror the bits of each group around its centre and invert them.
  for (genvar g = 0; g < N_GROUPS; g++) begin : g_group
    for (genvar i = 0; i < GROUP_W; i++) begin : g_bit
      assign w_grp_rev[g*GROUP_W + i] = ~in_word[g*GROUP_W + (GROUP_W - 1 - i)];
    end
  end

  always_comb begin
    out_word = in_word;
    case (mode)
      MODE_PASS:    out_word = in_word;
      MODE_INV:     out_word = ~in_word;
      MODE_GRP_REV: out_word = w_grp_rev;
      MODE_KEY_XOR: out_word = in_word ^ key;
      default:      out_word = in_word;
    endcase
  end

endmodule : encdec_transform
`default_nettype wire

// File: rtl/encoder_decoder_stream.sv
`default_nettype none
// ============================================================================
// Module   : encoder_decoder_stream
// Purpose  : Valid/ready stream block that encodes or decodes each word
//            through a self-inverse transform. One output register gives
//            one cycle of latency and full throughput. Mode and keystream
//            are (re)loaded by a cfg_load pulse while the block is quiet.
// Ports    : clk        rising-edge clock
//            reset      synchronous active-high reset
//            cfg_load   request to latch cfg_mode and reload the key
//            cfg_mode   transform mode (see encdec_pkg)
//            cfg_busy   a cfg_load would be ignored this cycle
//            in_valid   / in_ready  / in_data   upstream beat
//            out_valid  / out_ready / out_data  downstream beat
// Revision : 1.0 - initial release
// ============================================================================
module encoder_decoder_stream
  import encdec_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                GROUP_W  = 4,
  parameter logic [DATA_W-1:0] KEY_SEED = DATA_W'(8'h5A),
  parameter logic [DATA_W-1:0] KEY_STEP = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_load,
  input  logic [1:0]        cfg_mode,
  output logic              cfg_busy,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  logic [0:0]        r_state;
  logic [0:0]        w_state_next;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_key;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_xf_data;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_cfg_ok;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;
  // cfg_busy already covers in_valid, so an honoured load never
  // coincides with an input transfer.
  assign w_cfg_ok   = cfg_load & ~cfg_busy;

  encdec_transform #(
    .DATA_W  (DATA_W),
    .GROUP_W (GROUP_W)
  ) u_transform (
    .mode     (r_mode),
    .key      (r_key),
    .in_word  (in_data),
    .out_word (w_xf_data)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. An input transfer always (re)fills the output
  // register; only a drain with no refill empties it.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_in_xfer) w_state_next = ST_BUSY;
      ST_BUSY: if (w_out_xfer && !w_in_xfer) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. in_ready must not depend on in_valid.
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid = (r_state == ST_BUSY);
    in_ready  = ~out_valid | out_ready;
    cfg_busy  = out_valid | in_valid;
  end

  // --------------------------------------------------------------------------
  // Output data register. Loaded only on input transfer, so a stalled
  // beat stays stable while out_ready is low.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
    end else if (w_in_xfer) begin
      r_data <= w_xf_data;
    end
  end

  assign out_data = r_data;

  // --------------------------------------------------------------------------
  // Mode and keystream. The key used for a beat is the value before that
  // beat's advance, so encoder and decoder stay in lock-step.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= MODE_PASS;
      r_key  <= KEY_SEED;
    end else if (w_cfg_ok) begin
      r_mode <= cfg_mode;
      r_key  <= KEY_SEED;
    end else if (w_in_xfer && uses_key(r_mode)) begin
      r_key  <= r_key + KEY_STEP;
    end
  end

endmodule : encoder_decoder_stream
`default_nettype wire

// File: tb/tb_encoder_decoder_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_encoder_decoder_stream
// Purpose  : Self-checking bench for encoder_decoder_stream with a
//            transaction-level reference model, directed scenarios with
//            literal expectations, and a randomized stream phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encoder_decoder_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [1:0] cfg_mode;
  logic       cfg_busy;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  always #5 clk = ~clk;

  encoder_decoder_stream #(
    .DATA_W   (8),
    .GROUP_W  (4),
    .KEY_SEED (8'h5A),
    .KEY_STEP (8'h01)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_load  (cfg_load),
    .cfg_mode  (cfg_mode),
    .cfg_busy  (cfg_busy),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  // ---------------- reference model ----------------
  logic       m_valid;
  logic [7:0] m_data;
  logic [7:0] m_key;
  logic [1:0] m_mode;
  bit         m_in_x, m_out_x, m_cfg_ok;

  function automatic logic [7:0] ref_xf(input logic [1:0] m, input logic [7:0] x,
                                        input logic [7:0] k);
    logic [7:0] r;
    r = x;
    case (m)
      2'd0: r = x;
      2'd1: r = ~x;
      2'd2: begin
        for (int g = 0; g < 2; g++)
          for (int i = 0; i < 4; i++)
            r[g*4 + i] = ~x[g*4 + 3 - i];
      end
      default: r = x ^ k;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_mode  <= 2'd0;
      m_key   <= 8'h5A;
    end else begin
      m_in_x   = in_valid && (!m_valid || out_ready);
      m_out_x  = m_valid && out_ready;
      m_cfg_ok = cfg_load && !(m_valid || in_valid);
      if (m_cfg_ok) begin
        m_mode <= cfg_mode;
        m_key  <= 8'h5A;
      end
      if (m_in_x) begin
        m_data  <= ref_xf(m_mode, in_data, m_key);
        m_valid <= 1'b1;
        if (m_mode == 2'd3) m_key <= m_key + 8'h01;
      end else if (m_out_x) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      chk("model_out_valid", {7'd0, out_valid}, {7'd0, m_valid});
      if (m_valid) chk("model_out_data", out_data, m_data);
      chk("model_in_ready", {7'd0, in_ready}, {7'd0, (!m_valid || out_ready)});
      chk("model_cfg_busy", {7'd0, cfg_busy}, {7'd0, (m_valid || in_valid)});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clk); #1;
    in_valid = v;
    in_data  = d;
  endtask

  task automatic lit(input string name, input logic [7:0] exp);
    @(negedge clk);
    chk({name, "_valid"}, {7'd0, out_valid}, 8'd1);
    chk(name, out_data, exp);
  endtask

  task automatic cfg(input logic [1:0] m);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_load = 1'b1;
    cfg_mode = m;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_mode = 2'd0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    @(posedge clk); #1;
    checking = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_cfg_busy", {7'd0, cfg_busy}, 8'd0);

    // Group-reverse-invert round trip
    cfg(2'd2);
    drive(1'b1, 8'h12);
    drive(1'b1, 8'h7B);
    lit("grp_12", 8'h7B);
    drive(1'b0, 8'h00);
    lit("grp_7b", 8'h12);

    // Invert, back-to-back with no bubble
    cfg(2'd1);
    drive(1'b1, 8'hF0);
    drive(1'b1, 8'h3C);
    lit("inv_f0", 8'h0F);
    drive(1'b0, 8'h00);
    lit("inv_3c", 8'hC3);

    // Keystream and restart on fresh load
    cfg(2'd3);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h00);
    lit("key_0", 8'h5A);
    drive(1'b1, 8'hFF);
    lit("key_1", 8'h5B);
    drive(1'b0, 8'h00);
    lit("key_2", 8'hA3);
    cfg(2'd3);
    drive(1'b1, 8'h00);
    drive(1'b0, 8'h00);
    lit("key_restart", 8'h5A);

    // Back-pressure: held beat stable, second beat not lost
    drive(1'b1, 8'h11);
    @(posedge clk); #1;
    in_data = 8'h22; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", {7'd0, in_ready}, 8'd0);
      chk("stall_data", out_data, 8'h4A);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(1'b0, 8'h00);
    lit("stall_second", 8'h7E);

    // Ignored cfg_load while busy; honoured after drain
    drive(1'b1, 8'h33);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; cfg_load = 1'b1; cfg_mode = 2'd1;
    lit("busy_hold", 8'h6E);
    @(posedge clk); #1;
    cfg_load = 1'b0; out_ready = 1'b1;
    drive(1'b1, 8'h00);
    drive(1'b0, 8'h00);
    lit("cfg_ignored", 8'h5E);
    cfg(2'd1);
    drive(1'b1, 8'h00);
    drive(1'b0, 8'h00);
    lit("cfg_applied", 8'hFF);

    // Reset mid-stream drops the held beat
    drive(1'b1, 8'hA5);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
    lit("pre_reset", 8'h5A);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_valid", {7'd0, out_valid}, 8'd0);
    drive(1'b1, 8'h3C);
    drive(1'b0, 8'h00);
    lit("post_reset_mode0", 8'h3C);

    // Randomized stream
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      cfg_load  = ($urandom_range(0, 7) == 0);
      cfg_mode  = 2'($urandom);
    end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_encoder_decoder_stream
`default_nettype wire
